// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Conditions N_BTN raw push-button / switch inputs for the game logic. Each
//   channel is synchronised, debounced and edge-detected on CLK. The block
//   produces a clean level, one-cycle press and release pulses, and a
//   press-plus-auto-repeat pulse stream for held buttons.
//
// Build option:
//   BTN_AUTO_REPEAT_EN  - when defined, each channel gets a repeat FSM and a
//                         repeat counter. When undefined, no repeat logic is
//                         built and btn_repeat is identical to btn_press.
//
// Parameters:
//   N_BTN            number of independent channels
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to accept
//                    a level change (>= 1)
//   REPEAT_DELAY     cycles from a press pulse to the first repeat pulse (>= 1)
//   REPEAT_PERIOD    cycles between later repeat pulses (>= 1)
//
// Ports:
//   CLK          in   system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset, wins over btn_raw
//   btn_raw      in   asynchronous raw inputs, active-high
//   btn_level    out  debounced level
//   btn_press    out  one-cycle pulse in the first cycle btn_level is 1
//   btn_release  out  one-cycle pulse in the first cycle btn_level is 0
//   btn_repeat   out  btn_press OR'd with auto-repeat pulses while held
//
// Latency (raw change first sampled at edge E0, raw then stable):
//   the synchronised sample follows after E0+1, the debounce state accepts
//   the change after E0+1+DEBOUNCE_CYCLES and the registered outputs show it
//   after E0+2+DEBOUNCE_CYCLES. All outputs, pulses included, come from
//   flops, so every channel presents level and pulses in the same cycle.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    // Debounce counter only ever counts up to DEBOUNCE_CYCLES-1.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};

`ifdef BTN_AUTO_REPEAT_EN
    // The repeat counter is shared between the initial delay and the period.
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
    localparam logic [RP_W-1:0] RP_ONE         = RP_W'(1);
    localparam logic [RP_W-1:0] RP_ZERO        = {RP_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rp_state_t;
`endif

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_ch
            // Synchroniser stages.
            logic            r_s1;
            logic            r_s2;
            // Accepted (debounced) level and its stability counter.
            logic            r_deb;
            logic [DB_W-1:0] r_db_cnt;
            // Registered outputs for this channel.
            logic            r_level;
            logic            r_press;
            logic            r_release;
            logic            r_repeat;
            // Debounced level differs from what the outputs currently show.
            logic            w_rise;
            logic            w_fall;

            assign w_rise = r_deb & ~r_level;
            assign w_fall = ~r_deb & r_level;

            // Two-flop synchroniser for the asynchronous raw input.
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= btn_raw[g];
                    r_s2 <= r_s1;
                end
            end

            // Debounce: accept s2 only after DEBOUNCE_CYCLES consecutive
            // disagreeing samples; any agreeing sample restarts the count.
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_deb    <= 1'b0;
                    r_db_cnt <= DB_ZERO;
                end else if (r_s2 == r_deb) begin
                    r_db_cnt <= DB_ZERO;
                end else if (r_db_cnt == DB_LAST) begin
                    r_deb    <= r_s2;
                    r_db_cnt <= DB_ZERO;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_ONE;
                end
            end

            // Output level and edge pulses; a pulse is high exactly in the
            // first cycle the registered level shows the new value.
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_level   <= r_deb;
                    r_press   <= w_rise;
                    r_release <= w_fall;
                end
            end

`ifdef BTN_AUTO_REPEAT_EN
            rp_state_t       r_state;
            logic [RP_W-1:0] r_rp_cnt;

            // Auto-repeat FSM. It runs on the debounced level one cycle ahead
            // of the outputs, so its registered pulse lines up with btn_press
            // (press+0) and a fall suppresses any pulse in the release cycle.
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_state  <= ST_IDLE;
                    r_rp_cnt <= RP_ZERO;
                    r_repeat <= 1'b0;
                end else begin
                    r_repeat <= w_rise;
                    case (r_state)
                        ST_IDLE: begin
                            r_rp_cnt <= RP_ZERO;
                            if (w_rise) begin
                                r_state <= ST_DELAY;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_DELAY: begin
                            if (!r_deb) begin
                                r_state  <= ST_IDLE;
                                r_rp_cnt <= RP_ZERO;
                            end else if (r_rp_cnt == RP_DELAY_LAST) begin
                                r_state  <= ST_REPEAT;
                                r_rp_cnt <= RP_ZERO;
                                r_repeat <= 1'b1;
                            end else begin
                                r_rp_cnt <= r_rp_cnt + RP_ONE;
                            end
                        end
                        ST_REPEAT: begin
                            if (!r_deb) begin
                                r_state  <= ST_IDLE;
                                r_rp_cnt <= RP_ZERO;
                            end else if (r_rp_cnt == RP_PERIOD_LAST) begin
                                r_rp_cnt <= RP_ZERO;
                                r_repeat <= 1'b1;
                            end else begin
                                r_rp_cnt <= r_rp_cnt + RP_ONE;
                            end
                        end
                        default: begin
                            r_state  <= ST_IDLE;
                            r_rp_cnt <= RP_ZERO;
                        end
                    endcase
                end
            end
`else
            // Without auto-repeat the repeat output is a copy of the press pulse.
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_repeat <= 1'b0;
                end else begin
                    r_repeat <= w_rise;
                end
            end
`endif

            assign btn_level[g]   = r_level;
            assign btn_press[g]   = r_press;
            assign btn_release[g] = r_release;
            assign btn_repeat[g]  = r_repeat;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Scoreboard bench for button_conditioner with N_BTN=4, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Each stimulus step pushes the expected
// output snapshots (cycle number plus all four outputs) into a queue; a
// monitor on the falling clock edge pops and compares an entry whenever any
// pulse is present or the head entry is due in the current cycle.
//
// Timing used for expectations: an input driven after the falling edge of
// cycle k is first sampled at rising edge k+1, and the outputs show the
// accepted change after rising edge k+7 (2 sync stages + 4 debounce + 1).
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N_BTN = 4;
    localparam int DB    = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;
    localparam int LAT   = DB + 3;

`ifdef BTN_AUTO_REPEAT_EN
    localparam bit AUTO_RPT = 1'b1;
`else
    localparam bit AUTO_RPT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    button_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 CLK = ~CLK;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] rpt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   done   = 1'b0;
    bit   final_done = 1'b0;

    task automatic push(input int c, input logic [3:0] l, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] q);
        exp_t e;
        e.cyc = c;
        e.lvl = l;
        e.prs = p;
        e.rel = r;
        e.rpt = q;
        sb.push_back(e);
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: compare against the scoreboard away from the active edge.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (cyc > 0) begin
            if (((btn_press | btn_release | btn_repeat) !== 4'b0000) ||
                (sb.size() > 0 && sb[0].cyc == cyc)) begin
                n_chk = n_chk + 1;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_output cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b, want no pulse",
                             cyc, btn_level, btn_press, btn_release, btn_repeat);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc == cyc && btn_level === e.lvl && btn_press === e.prs &&
                        btn_release === e.rel && btn_repeat === e.rpt) begin
                        n_pass = n_pass + 1;
                    end else begin
                        $display("FAIL sb_entry cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b, want cyc=%0d lvl=%b prs=%b rel=%b rpt=%b",
                                 cyc, btn_level, btn_press, btn_release, btn_repeat,
                                 e.cyc, e.lvl, e.prs, e.rel, e.rpt);
                    end
                end
            end
            if (done && !final_done) begin
                final_done = 1'b1;
                n_chk = n_chk + 1;
                if (sb.size() == 0) begin
                    n_pass = n_pass + 1;
                end else begin
                    $display("FAIL sb_drained got %0d pending entries (head cyc=%0d), want 0",
                             sb.size(), sb[0].cyc);
                end
            end
        end
    end

    initial begin : stim
        int k;
        int p;
        int p2;

        // Scenario 1: reset held with all buttons pressed, outputs stay 0.
        reset   = 1'b1;
        btn_raw = 4'b0000;
        for (int c = 1; c <= 7; c++) push(c, 4'h0, 4'h0, 4'h0, 4'h0);
        go(2);
        btn_raw = 4'b1111;
        go(5);
        reset = 1'b0;                       // first reset-low edge is cyc+1
        k = cyc;
        push(k + LAT, 4'hF, 4'hF, 4'h0, 4'hF);
        push(k + 2 * LAT, 4'h0, 4'h0, 4'hF, 4'h0);
        go(LAT);
        btn_raw = 4'b0000;
        go(20);

        // Scenario 2a: 3-cycle glitch on channel 0 is rejected.
        k = cyc;
        push(k + 7, 4'h0, 4'h0, 4'h0, 4'h0);
        push(k + 8, 4'h0, 4'h0, 4'h0, 4'h0);
        push(k + 10, 4'h0, 4'h0, 4'h0, 4'h0);
        btn_raw = 4'b0001;
        go(3);
        btn_raw = 4'b0000;
        go(15);

        // Scenario 2b: 1-cycle dip restarts the debounce count.
        k = cyc;
        push(k + 10, 4'h0, 4'h0, 4'h0, 4'h0);
        push(k + 11, 4'h1, 4'h1, 4'h0, 4'h1);
        push(k + 17, 4'h0, 4'h0, 4'h1, 4'h0);
        btn_raw = 4'b0001;
        go(3);
        btn_raw = 4'b0000;
        go(1);
        btn_raw = 4'b0001;
        go(6);
        btn_raw = 4'b0000;
        go(20);

        // Scenario 3: channel 1 held; release lands where a repeat would be.
        k = cyc;
        p = k + LAT;
        push(p, 4'h2, 4'h2, 4'h0, 4'h2);
        if (AUTO_RPT) begin
            for (int j = 0; j < 7; j++) push(p + RD + RP * j, 4'h2, 4'h0, 4'h0, 4'h2);
        end
        push(p + 31, 4'h0, 4'h0, 4'h2, 4'h0);
        btn_raw = 4'b0010;
        go(31);
        btn_raw = 4'b0000;
        go(20);

        // Scenario 4: channels 2 and 3 together, pulses one cycle wide.
        k = cyc;
        push(k + 7, 4'hC, 4'hC, 4'h0, 4'hC);
        push(k + 8, 4'hC, 4'h0, 4'h0, 4'h0);
        push(k + 15, 4'h0, 4'h0, 4'hC, 4'h0);
        btn_raw = 4'b1100;
        go(8);
        btn_raw = 4'b0000;
        go(20);

        // Scenario 5: reset during the repeat delay, button still held.
        k = cyc;
        p = k + LAT;
        p2 = p + 12;
        push(p, 4'h1, 4'h1, 4'h0, 4'h1);
        push(p + 1, 4'h1, 4'h0, 4'h0, 4'h0);
        push(p + 5, 4'h0, 4'h0, 4'h0, 4'h0);
        push(p2, 4'h1, 4'h1, 4'h0, 4'h1);
        if (AUTO_RPT) begin
            push(p2 + RD, 4'h1, 4'h0, 4'h0, 4'h1);
            push(p2 + RD + RP, 4'h1, 4'h0, 4'h0, 4'h1);
        end
        push(p2 + 15, 4'h0, 4'h0, 4'h1, 4'h0);
        btn_raw = 4'b0001;
        go(11);
        reset = 1'b1;                       // sampled at edge p+5
        go(1);
        reset = 1'b0;
        go(15);                             // now at cycle p2+8
        btn_raw = 4'b0000;
        go(20);

        done = 1'b1;
        go(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
